// File: rtl/async_fifo_wr_flag_gen_if.sv
// Write-side bundle between the async FIFO write port and its flag generator.
// A write is accepted on a clk_A edge when wr_en is high and the pre-edge full is low.
// wr_en while full is dropped by the FIFO and recorded in overflow; there is no backpressure beyond full.
interface async_fifo_wr_flag_gen_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                  wr_en;
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr_gray;
  logic                  ovf_clr;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wr_level;
  logic                  overflow;
  logic [ADDR_WIDTH:0]   wr_ptr_gray;

  modport master (
    output wr_en, wr_ptr, rd_ptr_gray, ovf_clr,
    input  full, almost_full, wr_level, overflow, wr_ptr_gray
  );

  modport slave (
    input  wr_en, wr_ptr, rd_ptr_gray, ovf_clr,
    output full, almost_full, wr_level, overflow, wr_ptr_gray
  );
endinterface

// File: rtl/async_fifo_wr_flag_gen.sv
// Write-domain flag generator: synchronises the Gray read pointer and registers full, overflow and wr_ptr_gray.
// Define WR_FLAG_LEVEL_EN to build the wr_level / almost_full subtractor; otherwise both are tied to 0.
module async_fifo_wr_flag_gen #(
  parameter int ADDR_WIDTH   = 3,
  parameter int DEPTH        = 1 << ADDR_WIDTH,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                   clk_A,
  input  logic                   rst_A,
  async_fifo_wr_flag_gen_if.slave bus
);
  localparam int PW = ADDR_WIDTH + 1;

  if (SYNC_STAGES < 2 || DEPTH != (1 << ADDR_WIDTH) || AFULL_THRESH > DEPTH) begin : g_param_check
    $error("async_fifo_wr_flag_gen: illegal parameter combination");
  end

  // The flag registers form the final synchroniser stage, so only SYNC_STAGES-1 plain flops precede them.
  logic [PW-1:0] sync_q [SYNC_STAGES-1];
  logic [PW-1:0] rq_next;
  logic [PW-1:0] rd_bin_next;
  logic [PW-1:0] wr_next;
  logic          accept;
  logic          full_next;

  logic          full_q;
  logic          ovf_q;
  logic [PW-1:0] gray_q;

  always_ff @(posedge clk_A or negedge rst_A) begin
    if (!rst_A) begin
      for (int i = 0; i < SYNC_STAGES - 1; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.rd_ptr_gray;
      for (int i = 1; i < SYNC_STAGES - 1; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rq_next = sync_q[SYNC_STAGES-2];

  always_comb begin
    rd_bin_next = '0;
    for (int i = 0; i < PW; i++) rd_bin_next[i] = ^(rq_next >> i);
  end

  assign accept    = bus.wr_en & ~full_q;
  assign wr_next   = bus.wr_ptr + PW'(accept);
  assign full_next = (wr_next[PW-1] != rd_bin_next[PW-1]) &&
                     (wr_next[PW-2:0] == rd_bin_next[PW-2:0]);

  always_ff @(posedge clk_A or negedge rst_A) begin
    if (!rst_A) begin
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
      gray_q <= '0;
    end else begin
      full_q <= full_next;
      gray_q <= wr_next ^ (wr_next >> 1);
      // A blocked write on the same edge as a clear keeps the flag set.
      if (bus.wr_en && full_q)  ovf_q <= 1'b1;
      else if (bus.ovf_clr)     ovf_q <= 1'b0;
    end
  end

  assign bus.full        = full_q;
  assign bus.overflow    = ovf_q;
  assign bus.wr_ptr_gray = gray_q;

`ifdef WR_FLAG_LEVEL_EN
  logic [PW-1:0] level_next;
  logic [PW-1:0] level_q;
  logic          afull_q;

  assign level_next = wr_next - rd_bin_next;

  always_ff @(posedge clk_A or negedge rst_A) begin
    if (!rst_A) begin
      level_q <= '0;
      afull_q <= 1'b0;
    end else begin
      level_q <= level_next;
      afull_q <= (level_next >= PW'(AFULL_THRESH));
    end
  end

  assign bus.wr_level    = level_q;
  assign bus.almost_full = afull_q;
`else
  assign bus.wr_level    = '0;
  assign bus.almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo_wr_flag_gen.sv
// Bench for async_fifo_wr_flag_gen with a FIFO write pointer model in the loop.
// Expected flags come from write/read counts and the sampled read-pointer history.
module tb_async_fifo_wr_flag_gen;
  localparam int AW    = 3;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam int SYNC  = 2;
  localparam int AFULL = DEPTH - 1;
  localparam int VW    = 2 * PW + 3;

  logic clk_A = 1'b0;
  logic rst_A = 1'b0;
  always #5 clk_A = ~clk_A;

  async_fifo_wr_flag_gen_if #(.ADDR_WIDTH(AW)) bus ();

  async_fifo_wr_flag_gen #(
    .ADDR_WIDTH(AW), .DEPTH(DEPTH), .SYNC_STAGES(SYNC), .AFULL_THRESH(AFULL)
  ) dut (
    .clk_A(clk_A),
    .rst_A(rst_A),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [VW-1:0] exp_q[$];

  // reference model state
  logic          m_full, m_afull, m_ovf;
  logic [PW-1:0] m_level, m_gray;
  logic [PW-1:0] hist[$];
  logic [PW-1:0] rd_bin;

  function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] from_gray(input logic [PW-1:0] g);
    for (int i = 0; i < (1 << PW); i++)
      if (to_gray(PW'(i)) == g) return PW'(i);
    return '0;
  endfunction

  function automatic logic [VW-1:0] observed();
    return {bus.full, bus.almost_full, bus.wr_level, bus.overflow, bus.wr_ptr_gray};
  endfunction

  task automatic set_rd(input logic [PW-1:0] b);
    rd_bin = b;
    bus.rd_ptr_gray = to_gray(b);
  endtask

  task automatic model_reset();
    m_full = 0; m_afull = 0; m_ovf = 0; m_level = '0; m_gray = '0;
    hist = {};
    for (int i = 0; i < SYNC - 1; i++) hist.push_back('0);
    bus.wr_en = 0; bus.ovf_clr = 0; bus.wr_ptr = '0;
    set_rd('0);
  endtask

  task automatic tick();
    logic          acc;
    logic [PW-1:0] nxt, rq, lvl;
    logic          afull_e;
    logic [PW-1:0] level_e;
    @(posedge clk_A);
    acc = bus.wr_en && !m_full;
    nxt = bus.wr_ptr + PW'(acc);
    rq  = hist.pop_front();
    hist.push_back(bus.rd_ptr_gray);
    lvl = nxt - from_gray(rq);
    if (bus.wr_en && m_full) m_ovf = 1;
    else if (bus.ovf_clr)    m_ovf = 0;
    m_full  = (int'(lvl) == DEPTH);
    m_level = lvl;
    m_afull = (int'(lvl) >= AFULL);
    m_gray  = to_gray(nxt);
`ifdef WR_FLAG_LEVEL_EN
    afull_e = m_afull; level_e = m_level;
`else
    afull_e = 1'b0;    level_e = '0;
`endif
    exp_q.push_back({m_full, afull_e, level_e, m_ovf, m_gray});
    #1;
    bus.wr_ptr = nxt;
  endtask

  task automatic test_reset();
    logic [VW-1:0] got;
    rst_A = 0;
    for (int i = 0; i < 4; i++) begin
      bus.wr_en = 1'($urandom_range(0, 1));
      bus.ovf_clr = 1'($urandom_range(0, 1));
      bus.wr_ptr = PW'($urandom_range(0, 15));
      bus.rd_ptr_gray = PW'($urandom_range(0, 15));
      @(negedge clk_A);
      got = observed();
      checks++;
      if (got !== '0) begin
        errors++;
        $display("FAIL reset_hold %0d got %h want 0", i, got);
      end
    end
    model_reset();
    @(negedge clk_A);
    rst_A = 1;
    tick();
    got = observed();
    checks++;
    if (got !== exp_q.pop_front() || bus.full !== 1'b0 || bus.wr_level !== '0) begin
      errors++;
      $display("FAIL reset_release got %h want 0", got);
    end
  endtask

  task automatic test_fill_overflow();
    logic [VW-1:0] got, want;
    set_rd('0);
    bus.wr_en = 1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      got = observed(); want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL fill write %0d got %h want %h", i, got, want);
      end
      checks++;
      if (bus.full !== (i >= 8)) begin
        errors++;
        $display("FAIL fill_full write %0d got %b want %b", i, bus.full, (i >= 8));
      end
`ifdef WR_FLAG_LEVEL_EN
      checks++;
      if (bus.almost_full !== (i >= 7)) begin
        errors++;
        $display("FAIL fill_afull write %0d got %b want %b", i, bus.almost_full, (i >= 7));
      end
`endif
    end
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set got %b want 1", bus.overflow);
    end
    // clear, then set-wins, then clear again
    for (int k = 0; k < 3; k++) begin
      bus.wr_en = (k == 1);
      bus.ovf_clr = 1;
      tick();
      got = observed(); want = exp_q.pop_front();
      checks++;
      if (got !== want || bus.overflow !== (k == 1)) begin
        errors++;
        $display("FAIL ovf_clr step %0d got %h want %h", k, got, want);
      end
    end
    bus.wr_en = 0; bus.ovf_clr = 0;
  endtask

  task automatic test_sync_latency();
    logic [VW-1:0] got, want;
    set_rd(PW'(1));
    for (int e = 1; e <= 2; e++) begin
      tick();
      got = observed(); want = exp_q.pop_front();
      checks++;
      if (got !== want || bus.full !== (e == 1)) begin
        errors++;
        $display("FAIL sync_latency edge %0d got %h want %h", e, got, want);
      end
    end
`ifdef WR_FLAG_LEVEL_EN
    checks++;
    if (bus.wr_level !== PW'(7)) begin
      errors++;
      $display("FAIL sync_level got %0d want 7", bus.wr_level);
    end
`endif
  endtask

  task automatic test_wrap();
    logic [VW-1:0] got, want;
    set_rd(PW'(8));
    bus.wr_en = 0;
    for (int i = 0; i < 10; i++) begin
      bus.wr_en = (i >= 2);
      tick();
      got = observed(); want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL wrap step %0d got %h want %h", i, got, want);
      end
    end
    checks++;
    if (bus.full !== 1'b1 || bus.wr_ptr_gray !== '0) begin
      errors++;
      $display("FAIL wrap_full got full=%b gray=%h want full=1 gray=0", bus.full, bus.wr_ptr_gray);
    end
    bus.wr_en = 0;
  endtask

  task automatic test_gray_stream();
    logic [VW-1:0] got, want;
    logic [PW-1:0] prev;
    rst_A = 0;
    model_reset();
    @(negedge clk_A);
    rst_A = 1;
    prev = bus.wr_ptr_gray;
    bus.wr_en = 1;
    for (int i = 0; i < 16; i++) begin
      set_rd(bus.wr_ptr);
      tick();
      got = observed(); want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL gray_stream %0d got %h want %h", i, got, want);
      end
      checks++;
      if ($countones(prev ^ bus.wr_ptr_gray) != 1) begin
        errors++;
        $display("FAIL gray_onebit %0d got %h after %h want one bit change", i, bus.wr_ptr_gray, prev);
      end
      prev = bus.wr_ptr_gray;
    end
    bus.wr_en = 0;
  endtask

  task automatic test_random(input int n);
    logic [VW-1:0] got, want;
    for (int i = 0; i < n; i++) begin
      bus.wr_en = ($urandom_range(0, 3) != 0);
      if (rd_bin != bus.wr_ptr && $urandom_range(0, 2) != 0) set_rd(rd_bin + 1'b1);
      bus.ovf_clr = ($urandom_range(0, 7) == 0);
      tick();
      got = observed(); want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random %0d got %h want %h", i, got, want);
      end
    end
    bus.wr_en = 0; bus.ovf_clr = 0;
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] got, want;
    test_random(20);
    #3;
    rst_A = 0;
    #1;
    got = observed();
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_mid got %h want 0", got);
    end
    model_reset();
    @(negedge clk_A);
    rst_A = 1;
    for (int i = 0; i < 3; i++) begin
      bus.wr_en = 1;
      tick();
      got = observed(); want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_rebuild %0d got %h want %h", i, got, want);
      end
    end
    bus.wr_en = 0;
  endtask

  initial begin
    bus.wr_en = 0; bus.ovf_clr = 0; bus.wr_ptr = '0; bus.rd_ptr_gray = '0;
    rd_bin = '0;
    test_reset();
    test_fill_overflow();
    test_sync_latency();
    test_wrap();
    test_gray_stream();
    test_random(300);
    test_reset_mid();
    test_random(200);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
